// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes, priority-mode codes and state encoding for the 8-way result arbiter
package arb_pkg;
    localparam int NREQ       = 8;
    localparam int SEL_W      = 3;
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;
    typedef enum logic {ST_EMPTY, ST_FULL} state_t;
endpackage

// File: rtl/mux8to1.sv
// mux8to1: 8:1 select of DW-bit lanes
//   d   in  8*DW  lane i in bits [i*DW +: DW]
//   sel in  3     lane index
//   y   out DW    selected lane
module mux8to1 #(parameter int DW = 8) (
    input  logic [8*DW-1:0] d,
    input  logic [2:0]      sel,
    output logic [DW-1:0]   y
);
    assign y = d[sel*DW +: DW];
endmodule

// File: rtl/rr_pick8.sv
// rr_pick8: combinational winner pick over 8 requests, rotating from ptr or fixed from index 0
//   req    in  8  request vector
//   ptr    in  3  first index to scan in round-robin mode
//   mode   in  1  0 = round-robin, 1 = fixed priority (ptr ignored)
//   any    out 1  at least one request present
//   winner out 3  selected index
//   onehot out 8  one-hot of winner, 0 when no request
module rr_pick8 import arb_pkg::*; (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mode,
    output logic             any,
    output logic [SEL_W-1:0] winner,
    output logic [NREQ-1:0]  onehot
);
    logic [SEL_W-1:0] base;
    assign base   = mode ? '0 : ptr;
    assign any    = |req;
    assign onehot = any ? NREQ'(1) << winner : '0;
    // scan downward so the request closest to base is the last one written
    always_comb begin
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[base + SEL_W'(k)]) winner = base + SEL_W'(k);
    end
endmodule

// File: rtl/rr_arb8_ctrl.sv
// rr_arb8_ctrl: 8-way arbiter sharing one DW-bit result path, registered output on valid/ready
//   clk       in   1     rising-edge clock
//   rst_n     in   1     async active-low reset
//   req       in   8     requests, held until granted
//   req_data  in   8*DW  requester i data in [i*DW +: DW]
//   gnt       out  8     one-hot grant, data captured at this edge
//   out_valid out  1     output register full
//   out_data  out  DW    captured winner data
//   out_src   out  3     captured winner index
//   out_ready in   1     downstream accept
//   busy      out  1     output full or any request pending
module rr_arb8_ctrl import arb_pkg::*; #(
    parameter int DW        = 8,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [SEL_W-1:0]   out_src,
    input  logic               out_ready,
    output logic               busy
);
    state_t           state;
    logic [SEL_W-1:0] ptr, winner;
    logic [NREQ-1:0]  onehot;
    logic [DW-1:0]    sel_data;
    logic             any, load;
    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr),
        .mode   (PRIO_MODE == PRIO_FIXED),
        .any    (any),
        .winner (winner),
        .onehot (onehot)
    );
    mux8to1 #(.DW(DW)) u_mux (
        .d   (req_data),
        .sel (winner),
        .y   (sel_data)
    );
    // a full register can reload in the same cycle it drains
    assign load      = (state == ST_EMPTY || out_ready) && any;
    assign gnt       = (rst_n && load) ? onehot : '0;
    assign out_valid = state == ST_FULL;
    assign busy      = out_valid | any;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            ptr      <= '0;
            out_data <= '0;
            out_src  <= '0;
        end else if (load) begin
            state    <= ST_FULL;
            out_data <= sel_data;
            out_src  <= winner;
            ptr      <= (PRIO_MODE == PRIO_RR) ? winner + SEL_W'(1) : '0;
        end else if (out_ready) begin
            state    <= ST_EMPTY;
        end
    end
endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// tb_rr_arb8_ctrl: directed scoreboard bench for round-robin and fixed-priority arbiter instances
module tb_rr_arb8_ctrl;
    typedef struct packed {
        logic [7:0] d;
        logic [2:0] s;
    } exp_t;
    logic        clk = 0, rst_n = 0;
    logic [7:0]  req = 0, req_f = 0, gnt, gnt_f;
    logic [63:0] req_data, req_data_f;
    logic        out_valid, out_valid_f, out_ready = 1, out_ready_f = 1, busy, busy_f;
    logic [7:0]  out_data, out_data_f;
    logic [2:0]  out_src, out_src_f;
    exp_t        q[$], qf[$];
    int          n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    rr_arb8_ctrl #(.DW(8), .PRIO_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .busy(busy)
    );
    rr_arb8_ctrl #(.DW(8), .PRIO_MODE(1)) dfx (
        .clk(clk), .rst_n(rst_n), .req(req_f), .req_data(req_data_f), .gnt(gnt_f),
        .out_valid(out_valid_f), .out_data(out_data_f), .out_src(out_src_f),
        .out_ready(out_ready_f), .busy(busy_f)
    );
    function automatic logic [63:0] pat();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'hA0 + 8'(i);
        return v;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic settle();
        #1;
    endtask
    task automatic grant(input string name, input logic [7:0] g, input logic [7:0] d, input logic [2:0] s);
        settle();
        chk(name, 32'(gnt), 32'(g));
        q.push_back('{d: d, s: s});
    endtask
    initial begin
        req_data   = pat();
        req_data_f = pat();
        // monitor: a transfer is consumed at the next edge whenever valid & ready at the negedge
        fork
            forever begin
                @(negedge clk);
                if (rst_n && out_valid && out_ready) begin
                    if (q.size() == 0) chk("rr_unexpected_out", {21'b0, out_data, out_src}, 32'hFFFF_FFFF);
                    else chk("rr_out", {21'b0, out_data, out_src}, {21'b0, q.pop_front()});
                end
                if (rst_n && out_valid_f && out_ready_f) begin
                    if (qf.size() == 0) chk("fx_unexpected_out", {21'b0, out_data_f, out_src_f}, 32'hFFFF_FFFF);
                    else chk("fx_out", {21'b0, out_data_f, out_src_f}, {21'b0, qf.pop_front()});
                end
            end
        join_none
        // reset with all requests asserted
        req = 8'hFF;
        #3;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_src", 32'(out_src), 0);
        chk("rst_busy", 32'(busy), 1);
        step();
        step();
        chk("rst_gnt_held", 32'(gnt), 0);
        rst_n = 1;
        // round-robin fairness: 01,02,...,80
        for (int k = 0; k < 8; k++) begin
            grant($sformatf("rr_gnt%0d", k), 8'(1) << k, 8'hA0 + 8'(k), 3'(k));
            step();
        end
        settle();
        chk("rr_wrap_gnt", 32'(gnt), 32'h01);
        req = 0;
        settle();
        chk("rr_idle_gnt", 32'(gnt), 0);
        step();
        chk("rr_drained", 32'(out_valid), 0);
        // backpressure
        req_data[3*8 +: 8] = 8'hA5;
        out_ready = 0;
        req = 8'h08;
        grant("bp_gnt", 8'h08, 8'hA5, 3);
        step();
        req_data[3*8 +: 8] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_no_gnt", 32'(gnt), 0);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'hA5);
            chk("bp_src", 32'(out_src), 3);
            step();
        end
        out_ready = 1;
        grant("bp_reload", 8'h08, 8'h5A, 3);
        step();
        req = 0;
        step();
        // skip/wrap from ptr=6
        req_data = pat();
        req = 8'h20;
        grant("sw_set_ptr", 8'h20, 8'hA5, 5);
        step();
        req = 8'h05;
        grant("sw_wrap", 8'h01, 8'hA0, 0);
        step();
        req = 8'h04;
        grant("sw_next", 8'h04, 8'hA2, 2);
        step();
        req = 0;
        step();
        req = 8'hFF;
        grant("sw_ptr3", 8'h08, 8'hA3, 3);
        step();
        req = 0;
        step();
        // async reset while holding a byte
        req_data[1*8 +: 8] = 8'h3C;
        out_ready = 0;
        req = 8'h02;
        settle();
        chk("mr_gnt", 32'(gnt), 32'h02);
        step();
        req = 0;
        settle();
        chk("mr_valid", 32'(out_valid), 1);
        chk("mr_data", 32'(out_data), 32'h3C);
        req = 8'hFF;
        rst_n = 0;
        settle();
        chk("mr_async_valid", 32'(out_valid), 0);
        chk("mr_async_data", 32'(out_data), 0);
        chk("mr_async_gnt", 32'(gnt), 0);
        step();
        rst_n = 1;
        out_ready = 1;
        req_data = pat();
        grant("mr_after_rst", 8'h01, 8'hA0, 0);
        step();
        req = 0;
        step();
        // fixed priority instance
        req_f = 8'h90;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("fx_gnt", 32'(gnt_f), 32'h10);
            qf.push_back('{d: 8'hA4, s: 4});
            step();
        end
        req_f = 8'h80;
        settle();
        chk("fx_gnt_last", 32'(gnt_f), 32'h80);
        qf.push_back('{d: 8'hA7, s: 7});
        step();
        req_f = 0;
        for (int i = 0; i < 20 && (q.size() != 0 || qf.size() != 0); i++) step();
        chk("sb_rr_empty", 32'(q.size()), 0);
        chk("sb_fx_empty", 32'(qf.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
